// File: rtl/ds_pkg.sv
// Shared delta-sigma constants and helpers, reused by the modulator and decimator sides.
package ds_pkg;

    localparam int unsigned CIC_ORDER = 3;

    // Accumulator width needed for an order-3 CIC at R = 2^dec_log2 (gain R^3 plus one bit).
    function automatic int unsigned cic_acc_w(input int unsigned dec_log2);
        return CIC_ORDER * dec_log2 + 1;
    endfunction

endpackage

// File: rtl/ds_in_sync.sv
// Two-flop synchroniser for the asynchronous delta-sigma bitstream.
module ds_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Resample d twice into the clk domain; both stages clear to 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ds_cic_decim.sv
// 3rd-order CIC decimator for the 1-bit delta-sigma link, R = 2^DEC_LOG2.
// Build option: DS_SIGNED_OUT_EN selects a two's-complement out_data (code - 2^(OUT_W-1));
// otherwise out_data is an unsigned offset-binary code.
module ds_cic_decim
    import ds_pkg::*;
#(
    parameter int unsigned DEC_LOG2 = 6,
    parameter int unsigned OUT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ds_in,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_sat
);

    localparam int unsigned ACC_W = cic_acc_w(DEC_LOG2);
    localparam int unsigned Y_W   = CIC_ORDER * DEC_LOG2;
    localparam logic [ACC_W-1:0] FULL_SCALE = ACC_W'(1) << Y_W;

    logic                x;
    logic [DEC_LOG2-1:0] dec_cnt;
    logic                strobe_c;
    logic [ACC_W-1:0]    i1, i2, i3;
    logic [ACC_W-1:0]    d1, d2, d3;
    logic [ACC_W-1:0]    c1_c, c2_c, c3_c;
    logic [ACC_W-1:0]    c3_q;
    logic                pend;
    logic                sat_c;
    logic [ACC_W-1:0]    y_c;
    logic [OUT_W-1:0]    code_c;

    ds_in_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ds_in),
        .q   (x)
    );

    assign strobe_c = (dec_cnt == '1);

    // Free-running decimation phase counter; wraps every R cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + DEC_LOG2'(1);
        end
    end

    // Integrator chain at the input rate; modulo wrap-around is intentional.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
        end else begin
            i1 <= i1 + ACC_W'(x);
            i2 <= i2 + i1;
            i3 <= i3 + i2;
        end
    end

    // Comb differences at the decimated rate.
    always_comb begin
        c1_c = i3 - d1;
        c2_c = c1_c - d2;
        c3_c = c2_c - d3;
    end

    // Comb delay registers and output-stage capture, updated only on the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1   <= '0;
            d2   <= '0;
            d3   <= '0;
            c3_q <= '0;
            pend <= 1'b0;
        end else begin
            pend <= strobe_c;
            if (strobe_c) begin
                d1   <= i3;
                d2   <= c1_c;
                d3   <= c2_c;
                c3_q <= c3_c;
            end
        end
    end

    // Clamp the single overflow value R^3 to full scale and rescale to OUT_W bits.
    always_comb begin
        sat_c  = (c3_q == FULL_SCALE);
        y_c    = sat_c ? (FULL_SCALE - ACC_W'(1)) : c3_q;
        code_c = OUT_W'(y_c >> (Y_W - OUT_W));
`ifdef DS_SIGNED_OUT_EN
        code_c = code_c ^ (OUT_W'(1) << (OUT_W - 1));
`endif
    end

    // Present the sample with a one-cycle strobe; out_sat is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= pend;
            if (pend) begin
                out_data <= code_c;
                if (sat_c) begin
                    out_sat <= 1'b1;
                end
            end
        end
    end

endmodule
